// File: rtl/arb_pkg.sv
//==============================================================================
// Module      : arb_pkg
// Description : Shared types and the round-robin pick function for the
//               single-owner resource arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package arb_pkg;

    localparam int ARB_MAX_REQ = 32;
    localparam int ARB_IDX_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                 any;
        logic [ARB_IDX_W-1:0] idx;
    } pick_t;

    // Scans downward so the lowest offset from last+1 is written last and wins;
    // offset == depth wraps back to last itself, the lowest priority.
    function automatic pick_t rr_pick(
        input logic [ARB_MAX_REQ-1:0] req,
        input logic [ARB_IDX_W-1:0]   last,
        input int                     depth
    );
        pick_t                p;
        logic [ARB_IDX_W-1:0] mask;
        logic [ARB_IDX_W-1:0] cand;
        p    = '0;
        mask = ARB_IDX_W'(depth - 1);
        for (int i = ARB_MAX_REQ; i >= 1; i--) begin
            if (i <= depth) begin
                cand = (last + ARB_IDX_W'(i)) & mask;
                if (req[cand]) begin
                    p.any = 1'b1;
                    p.idx = cand;
                end
            end
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_resource_arbiter_hot_bit.sv
//==============================================================================
// Module      : Hot_Bit
// Description : Binary index to one-hot decoder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module Hot_Bit #(
    parameter int DEPTH = 8
) (
    input  logic [$clog2(DEPTH)-1:0] idx,
    output logic [DEPTH-1:0]         onehot
);

    localparam int IW = $clog2(DEPTH);

    for (genvar i = 0; i < DEPTH; i++) begin : g_bit
        assign onehot[i] = (idx == IW'(i));
    end

endmodule

`default_nettype wire

// File: rtl/rr_resource_arbiter.sv
//==============================================================================
// Module      : rr_resource_arbiter
// Description : Round-robin arbiter for one single-owner resource with hold
//               limit and a mandatory one-cycle turnaround gap between owners.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_resource_arbiter
    import arb_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DEPTH-1:0]         req,
    input  logic                     done,
    output logic [DEPTH-1:0]         gnt,
    output logic [$clog2(DEPTH)-1:0] gnt_idx,
    output logic                     gnt_valid,
    output logic                     preempt
);

    localparam int IW = $clog2(DEPTH);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [IW-1:0] c_last_init = IW'(DEPTH - 1);
    localparam logic [HW-1:0] c_hold_max  = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_t      r_state;
    logic [IW-1:0]   r_gnt_idx;
    logic [IW-1:0]   r_last;
    logic            r_gnt_valid;
    logic            r_preempt;
    logic [HW-1:0]   r_hold_cnt;

    pick_t           w_pick;
    logic [IW-1:0]   w_win;
    logic            w_limit;
    logic            w_normal_rel;
    logic            w_release;
    logic [DEPTH-1:0] w_onehot;

    assign w_pick       = rr_pick(ARB_MAX_REQ'(req), ARB_IDX_W'(r_last), DEPTH);
    assign w_win        = w_pick.idx[IW-1:0];
    assign w_normal_rel = done | ~req[r_gnt_idx];
    assign w_release    = w_normal_rel | w_limit;

    if (IW < ARB_IDX_W) begin : g_pick_pad
        logic w_unused_hi;
        assign w_unused_hi = |w_pick.idx[ARB_IDX_W-1:IW];
    end

    if (MAX_HOLD != 0) begin : g_limit
        assign w_limit = (r_hold_cnt == c_hold_max);
    end else begin : g_no_limit
        assign w_limit = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt_idx   <= '0;
            r_last      <= c_last_init;
            r_gnt_valid <= 1'b0;
            r_preempt   <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE, GAP: begin
                    r_preempt   <= 1'b0;
                    r_gnt_valid <= 1'b0;
                    if (w_pick.any) begin
                        r_state     <= GRANT;
                        r_gnt_idx   <= w_win;
                        r_last      <= w_win;
                        r_hold_cnt  <= '0;
                        r_gnt_valid <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_state     <= GAP;
                        r_gnt_valid <= 1'b0;
                        // Only a pure hold-limit expiry is reported as preemption.
                        r_preempt   <= ~w_normal_rel;
                    end else if (r_hold_cnt != c_hold_max) begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_gnt_valid <= 1'b0;
                    r_preempt   <= 1'b0;
                end
            endcase
        end
    end

    Hot_Bit #(
        .DEPTH (DEPTH)
    ) u_hot_bit (
        .idx    (r_gnt_idx),
        .onehot (w_onehot)
    );

    assign gnt       = w_onehot & {DEPTH{r_gnt_valid}};
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign preempt   = r_preempt;

endmodule

`default_nettype wire

// File: tb/tb_rr_resource_arbiter.sv
//==============================================================================
// Module      : tb_rr_resource_arbiter
// Description : Directed self-checking bench for rr_resource_arbiter with a
//               per-cycle behavioural owner model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rr_resource_arbiter;

    localparam int DEPTH    = 8;
    localparam int MAX_HOLD = 4;

    logic             clk;
    logic             rst_n;
    logic [DEPTH-1:0] req;
    logic             done;
    logic [DEPTH-1:0] gnt;
    logic [2:0]       gnt_idx;
    logic             gnt_valid;
    logic             preempt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    rr_resource_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: owner = -1 means nobody holds the resource. A freed resource is
    // always re-arbitrated at the next edge, which yields the one-cycle gap.
    int m_owner;
    int m_held;
    int m_last;
    bit m_pre;
    int m_pick;

    function automatic int next_owner(input logic [DEPTH-1:0] r, input int last);
        for (int k = 1; k <= DEPTH; k++) begin
            if (r[(last + k) % DEPTH]) return (last + k) % DEPTH;
        end
        return -1;
    endfunction

    always_comb m_pick = next_owner(req, m_last);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_held  <= 0;
            m_last  <= DEPTH - 1;
            m_pre   <= 1'b0;
        end else if (m_owner >= 0) begin
            if (done || !req[m_owner] || (m_held + 1 >= MAX_HOLD)) begin
                m_pre   <= !(done || !req[m_owner]);
                m_owner <= -1;
            end else begin
                m_held <= m_held + 1;
            end
        end else begin
            m_pre <= 1'b0;
            if (m_pick >= 0) begin
                m_owner <= m_pick;
                m_last  <= m_pick;
                m_held  <= 0;
            end
        end
    end

    function automatic logic [DEPTH-1:0] model_gnt();
        return (m_owner >= 0) ? DEPTH'(1) << m_owner : '0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_gnt", 32'(gnt), 32'(model_gnt()));
            chk("model_gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
            chk("model_preempt", 32'(preempt), 32'(m_pre));
            if (m_owner >= 0) chk("model_gnt_idx", 32'(gnt_idx), 32'(m_owner));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [7:0] seq_gnt [11];
    logic       seq_pre [11];

    initial begin
        rst_n = 1'b1;
        req   = '0;
        done  = 1'b0;
        #3 rst_n = 1'b0;
        tick();
        tick();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_gnt_valid", 32'(gnt_valid), 32'h0);
        chk("reset_gnt_idx", 32'(gnt_idx), 32'h0);
        chk("reset_preempt", 32'(preempt), 32'h0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // Single requester, released by done together with dropping req.
        req = 8'h01;
        tick(); chk("s1_gnt_first", 32'(gnt), 32'h01);
        chk("s1_idx", 32'(gnt_idx), 32'h0);
        tick(); tick(); chk("s1_gnt_held", 32'(gnt), 32'h01);
        done = 1'b1; req = 8'h00;
        tick(); chk("s1_gap_gnt", 32'(gnt), 32'h0);
        chk("s1_gap_preempt", 32'(preempt), 32'h0);
        done = 1'b0;
        tick(); chk("s1_idle_gnt", 32'(gnt), 32'h0);

        // All requesting, each owner releases after one grant cycle.
        do_reset();
        req = 8'hFF; done = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            tick();
            if (k % 2 == 0) chk("s2_rr_gnt", 32'(gnt), 32'(8'h01 << ((k / 2) % 8)));
            else            chk("s2_rr_gap", 32'(gnt), 32'h0);
        end
        done = 1'b0; req = 8'h00;

        // Two requesters, no done: hold limit forces alternation.
        do_reset();
        seq_gnt = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h01};
        seq_pre = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        req = 8'h81;
        for (int k = 0; k < 11; k++) begin
            tick();
            chk("s3_hold_gnt", 32'(gnt), 32'(seq_gnt[k]));
            chk("s3_hold_preempt", 32'(preempt), 32'(seq_pre[k]));
        end
        req = 8'h00;

        // Owner 3 drops its request while 5 is waiting.
        do_reset();
        req = 8'h08;
        tick(); chk("s4_gnt3", 32'(gnt), 32'h08);
        req = 8'h20;
        tick(); chk("s4_gap_gnt", 32'(gnt), 32'h0);
        chk("s4_gap_preempt", 32'(preempt), 32'h0);
        tick(); chk("s4_gnt5", 32'(gnt), 32'h20);
        req = 8'h00;

        // done on the last allowed hold cycle is a normal release.
        do_reset();
        req = 8'h04;
        tick(); chk("s5_gnt_c1", 32'(gnt), 32'h04);
        tick(); tick(); tick(); chk("s5_gnt_c4", 32'(gnt), 32'h04);
        done = 1'b1;
        tick(); chk("s5_gap_gnt", 32'(gnt), 32'h0);
        chk("s5_gap_preempt", 32'(preempt), 32'h0);
        done = 1'b0; req = 8'h00;
        tick();

        // Asynchronous reset in the middle of a grant to requester 6.
        do_reset();
        req = 8'h40;
        tick(); chk("s6_gnt6", 32'(gnt), 32'h40);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_gnt", 32'(gnt), 32'h0);
        chk("s6_async_valid", 32'(gnt_valid), 32'h0);
        req = 8'h41;
        tick();
        rst_n = 1'b1;
        tick(); chk("s6_restart_gnt", 32'(gnt), 32'h01);
        req = 8'h00;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
